// File: rtl/dump_sequencer_pkg.sv
// Shared types and default sizes for the debug dump sequencer.
// Optional checksum byte is enabled by defining DUMP_CHECKSUM_EN.
package dump_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REG_RD,
        REG_TX,
        MEM_RD,
        MEM_TX,
        LAT_TX,
        CSUM_TX,
        FINISH
    } state_t;

    localparam int DEF_NB_R_INT    = 341;
    localparam int DEF_N_REGS      = 32;
    localparam int DEF_N_MEM_WORDS = 32;
    localparam int LAT_BYTES       = (DEF_NB_R_INT + 7) / 8;

    function automatic int lat_bytes_of(input int nb_bits);
        return (nb_bits + 7) / 8;
    endfunction

endpackage

// File: rtl/dump_sequencer_byte_serializer.sv
// Loads one word and offers it LSB byte first on a valid/ready byte port.
// Part of dump_sequencer (checksum option DUMP_CHECKSUM_EN lives in the top).
module byte_serializer
    import dump_sequencer_pkg::*;
#(
    parameter int NB_WORD = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [NB_WORD-1:0] i_word,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [7:0]         o_data,
    output logic               o_word_done
);
    localparam int NBYTES = NB_WORD / 8;
    localparam int CW     = $clog2(NBYTES + 1);

    logic [NB_WORD-1:0] r_shift;
    logic [CW-1:0]      r_left;
    logic               w_xfer;

    assign o_valid     = (r_left != '0);
    assign o_data      = r_shift[7:0];
    assign w_xfer      = o_valid && i_ready;
    assign o_word_done = w_xfer && (r_left == CW'(1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_shift <= '0;
            r_left  <= '0;
        end else if (i_load) begin
            r_shift <= i_word;
            r_left  <= CW'(NBYTES);
        end else if (w_xfer) begin
            r_shift <= r_shift >> 8;
            r_left  <= r_left - CW'(1);
        end
    end

endmodule

// File: rtl/dump_sequencer.sv
// Streams register file, data memory and a pipeline-latch snapshot out as bytes.
// Define DUMP_CHECKSUM_EN to append an XOR checksum byte after the latch bytes.
module dump_sequencer
    import dump_sequencer_pkg::*;
#(
    parameter int NB_REG      = 32,
    parameter int NB_R_INT    = DEF_NB_R_INT,
    parameter int N_REGS      = DEF_N_REGS,
    parameter int N_MEM_WORDS = DEF_N_MEM_WORDS
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NB_REG-1:0]   i_reg_data,
    input  logic [NB_REG-1:0]   i_mem_data,
    input  logic [NB_R_INT-1:0] i_latches_data,
    input  logic                i_tx_ready,
    output logic                o_tx_valid,
    output logic [7:0]          o_tx_data,
    output logic [4:0]          o_reg_addr,
    output logic [31:0]         o_mem_addr,
    output logic                o_busy,
    output logic                o_done
);
    localparam int LB    = lat_bytes_of(NB_R_INT);
    localparam int LAT_W = LB * 8;
    localparam int LCW   = $clog2(LB + 1);

`ifdef DUMP_CHECKSUM_EN
    localparam state_t LAT_NEXT = CSUM_TX;
`else
    localparam state_t LAT_NEXT = FINISH;
`endif

    state_t            r_state;
    state_t            w_state_next;
    logic [4:0]        r_reg_idx;
    logic [29:0]       r_mem_idx;
    logic [LCW-1:0]    r_lat_cnt;
    logic [LAT_W-1:0]  r_snap;
    logic              w_accept;
    logic              w_load;
    logic [NB_REG-1:0] w_word;
    logic              w_ser_valid;
    logic [7:0]        w_ser_data;
    logic              w_word_done;
    logic              w_reg_last;
    logic              w_mem_last;
    logic              w_lat_last;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    assign w_accept   = (r_state == IDLE) && i_start;
    assign w_load     = (r_state == REG_RD) || (r_state == MEM_RD);
    assign w_word     = (r_state == MEM_RD) ? i_mem_data : i_reg_data;
    assign w_reg_last = (r_reg_idx == 5'(N_REGS - 1));
    assign w_mem_last = (r_mem_idx == 30'(N_MEM_WORDS - 1));
    assign w_lat_last = (r_lat_cnt == LCW'(LB - 1));
    assign o_reg_addr = r_reg_idx;
    assign o_mem_addr = {r_mem_idx, 2'b00};
    assign o_busy     = (r_state != IDLE);
    assign o_done     = (r_state == FINISH);

    byte_serializer #(.NB_WORD(NB_REG)) u_ser (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_load      (w_load),
        .i_word      (w_word),
        .i_ready     (i_tx_ready),
        .o_valid     (w_ser_valid),
        .o_data      (w_ser_data),
        .o_word_done (w_word_done)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        o_tx_valid   = 1'b0;
        o_tx_data    = '0;
        case (r_state)
            IDLE:   if (i_start) w_state_next = REG_RD;
            REG_RD: w_state_next = REG_TX;
            REG_TX: begin
                o_tx_valid = w_ser_valid;
                o_tx_data  = w_ser_data;
                if (w_word_done) w_state_next = w_reg_last ? MEM_RD : REG_RD;
            end
            MEM_RD: w_state_next = MEM_TX;
            MEM_TX: begin
                o_tx_valid = w_ser_valid;
                o_tx_data  = w_ser_data;
                if (w_word_done) w_state_next = w_mem_last ? LAT_TX : MEM_RD;
            end
            LAT_TX: begin
                o_tx_valid = 1'b1;
                o_tx_data  = r_snap[7:0];
                if (i_tx_ready && w_lat_last) w_state_next = LAT_NEXT;
            end
`ifdef DUMP_CHECKSUM_EN
            CSUM_TX: begin
                o_tx_valid = 1'b1;
                o_tx_data  = r_csum;
                if (i_tx_ready) w_state_next = FINISH;
            end
`endif
            FINISH:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Indices advance only after the 4th byte of a word has gone out
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_reg_idx <= '0;
            r_mem_idx <= '0;
            r_lat_cnt <= '0;
            r_snap    <= '0;
        end else begin
            if (w_accept) begin
                r_reg_idx <= '0;
                r_mem_idx <= '0;
                r_lat_cnt <= '0;
                r_snap    <= LAT_W'(i_latches_data);
            end
            if (r_state == REG_TX && w_word_done && !w_reg_last)
                r_reg_idx <= r_reg_idx + 5'd1;
            if (r_state == MEM_TX && w_word_done && !w_mem_last)
                r_mem_idx <= r_mem_idx + 30'd1;
            if (r_state == LAT_TX && i_tx_ready) begin
                r_snap    <= r_snap >> 8;
                r_lat_cnt <= r_lat_cnt + LCW'(1);
            end
        end
    end

`ifdef DUMP_CHECKSUM_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_csum <= '0;
        else if (w_accept)
            r_csum <= '0;
        else if (o_tx_valid && i_tx_ready && r_state != CSUM_TX)
            r_csum <= r_csum ^ o_tx_data;
    end
`endif

endmodule

// File: tb/tb_dump_sequencer.sv
// Randomized self-checking bench for dump_sequencer against a byte-stream model.
// Honours DUMP_CHECKSUM_EN the same way as the design.
module tb_dump_sequencer;
    localparam int NREG = 32;
    localparam int NMEM = 32;
    localparam int NLAT = 341;
    localparam int LATB = (NLAT + 7) / 8;
`ifdef DUMP_CHECKSUM_EN
    localparam int TOTAL = 4*NREG + 4*NMEM + LATB + 1;
`else
    localparam int TOTAL = 4*NREG + 4*NMEM + LATB;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            ready;
    logic [31:0]     reg_data;
    logic [31:0]     mem_data;
    logic [NLAT-1:0] lat;
    logic            tx_valid;
    logic [7:0]      tx_data;
    logic [4:0]      reg_addr;
    logic [31:0]     mem_addr;
    logic            busy;
    logic            done;

    logic [31:0] regs [NREG];
    logic [31:0] mems [NMEM];
    logic [NLAT-1:0] lat_a;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    logic [7:0] stream_a [$];
    bit   active = 0, finished = 0, expect_done = 0, prev_stall = 0;
    logic [7:0] prev_data = '0;
    int   xfer_cnt = 0;
    int   ready_pct = 100;

    always #5 clk = ~clk;

    assign reg_data = regs[reg_addr];
    assign mem_data = mems[5'(mem_addr >> 2)];

    dump_sequencer dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_start        (start),
        .i_reg_data     (reg_data),
        .i_mem_data     (mem_data),
        .i_latches_data (lat),
        .i_tx_ready     (ready),
        .o_tx_valid     (tx_valid),
        .o_tx_data      (tx_data),
        .o_reg_addr     (reg_addr),
        .o_mem_addr     (mem_addr),
        .o_busy         (busy),
        .o_done         (done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Expected stream: regs, memory words (LSB first), zero-extended snapshot, optional XOR
    task automatic build_model();
        logic [LATB*8-1:0] s;
        logic [7:0] cs;
        exp_q.delete();
        for (int i = 0; i < NREG; i++)
            for (int b = 0; b < 4; b++) exp_q.push_back(regs[i][8*b +: 8]);
        for (int i = 0; i < NMEM; i++)
            for (int b = 0; b < 4; b++) exp_q.push_back(mems[i][8*b +: 8]);
        s = '0;
        s[NLAT-1:0] = lat;
        for (int b = 0; b < LATB; b++) exp_q.push_back(s[8*b +: 8]);
`ifdef DUMP_CHECKSUM_EN
        cs = '0;
        foreach (exp_q[k]) cs = cs ^ exp_q[k];
        exp_q.push_back(cs);
`else
        cs = '0;
`endif
    endtask

    initial begin
        ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            ready = (int'($urandom_range(0, 99)) < ready_pct);
        end
    end

    always @(negedge clk) begin
        if (active) begin
            if (expect_done) begin
                chk("done_pulse", done, 1);
                expect_done = 0;
                active = 0;
                finished = 1;
            end else begin
                chk("done_low", done, 0);
                chk("busy_high", busy, 1);
                if (prev_stall) begin
                    chk("hold_valid", tx_valid, 1);
                    chk("hold_data", tx_data, prev_data);
                end
                if (xfer_cnt < 4*NREG) begin
                    chk("reg_addr", reg_addr, xfer_cnt / 4);
                    chk("mem_addr_idle", mem_addr, 0);
                end else if (xfer_cnt < 4*(NREG+NMEM)) begin
                    chk("mem_addr", mem_addr, 4 * ((xfer_cnt - 4*NREG) / 4));
                end
                if (tx_valid && ready) begin
                    if (exp_q.size() == 0) fail_now("extra_byte");
                    else chk("byte", tx_data, exp_q.pop_front());
                    got_q.push_back(tx_data);
                    xfer_cnt++;
                    if (exp_q.size() == 0) expect_done = 1;
                end
                prev_stall = tx_valid && !ready;
                prev_data  = tx_data;
            end
        end
    end

    task automatic start_dump(input int pct);
        ready_pct = pct;
        @(posedge clk);
        #2;
        build_model();
        got_q.delete();
        xfer_cnt = 0;
        finished = 0;
        expect_done = 0;
        prev_stall = 0;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        active = 1;
    endtask

    task automatic wait_done();
        for (int c = 0; c < 20000 && !finished; c++) @(posedge clk);
        if (!finished) begin
            fail_now("dump_timeout");
            active = 0;
        end
        chk("total_bytes", got_q.size(), TOTAL);
    endtask

    task automatic wait_xfers(input int n);
        for (int c = 0; c < 5000 && xfer_cnt < n; c++) @(posedge clk);
        if (xfer_cnt < n) fail_now("xfer_wait_timeout");
    endtask

    task automatic rand_lat();
        for (int k = 0; k < NLAT; k++) lat[k] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        lat = '0;
        for (int i = 0; i < NREG; i++) regs[i] = 32'h1000_0000 + i;
        for (int i = 0; i < NMEM; i++) mems[i] = $urandom;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", tx_valid, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_reg_addr", reg_addr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Incrementing register pattern, always ready
        rand_lat();
        lat_a = lat;
        start_dump(100);
        wait_done();
        stream_a = got_q;
        if (got_q.size() >= 8) begin
            chk("first_b0", got_q[0], 8'h00);
            chk("first_b1", got_q[1], 8'h00);
            chk("first_b2", got_q[2], 8'h00);
            chk("first_b3", got_q[3], 8'h10);
            chk("first_b4", got_q[4], 8'h01);
            chk("first_b5", got_q[5], 8'h00);
            chk("first_b6", got_q[6], 8'h00);
            chk("first_b7", got_q[7], 8'h10);
        end
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);

        // Latch end bits
        lat = '0;
        lat[0] = 1'b1;
        lat[340] = 1'b1;
        start_dump(100);
        wait_done();
        if (got_q.size() >= 4*(NREG+NMEM) + LATB) begin
            chk("lat_byte0", got_q[4*(NREG+NMEM)], 8'h01);
            chk("lat_byte42", got_q[4*(NREG+NMEM) + LATB - 1], 8'h10);
        end

        // Same data as the first run with 30% ready; latches change after start
        lat = lat_a;
        start_dump(30);
        rand_lat();
        wait_done();
        chk("stream_len_eq", got_q.size(), stream_a.size());
        if (got_q.size() == stream_a.size())
            foreach (stream_a[k]) chk("stream_eq", got_q[k], stream_a[k]);

        // Reset mid-dump then restart from register 0
        for (int i = 0; i < NMEM; i++) mems[i] = $urandom;
        start_dump(100);
        wait_xfers(50);
        #2;
        active = 0;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", tx_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data", tx_data, 0);
        chk("mid_rst_reg_addr", reg_addr, 0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        start_dump(60);
        wait_done();
        if (got_q.size() >= 4) chk("restart_b3", got_q[3], 8'h10);

        // Single non-zero register; a second start during the dump is ignored
        for (int i = 0; i < NREG; i++) regs[i] = '0;
        for (int i = 0; i < NMEM; i++) mems[i] = '0;
        regs[1] = 32'h0000_00A5;
        lat = '0;
        start_dump(100);
        wait_xfers(100);
        @(posedge clk);
        #2;
        rand_lat();
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_done();
        if (got_q.size() >= 5) chk("a5_byte", got_q[4], 8'hA5);
`ifdef DUMP_CHECKSUM_EN
        if (got_q.size() == TOTAL) chk("csum_byte", got_q[TOTAL-1], 8'hA5);
`endif
        repeat (3) @(negedge clk);
        chk("no_restart_busy", busy, 0);
        chk("no_restart_valid", tx_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dump_sequencer.md
DUMP_SEQUENCER -- requirements
Module: dump_sequencer

Interface
REQ-001 Parameter NB_REG, default 32, width of register-file and data-memory words.
REQ-002 Parameter NB_R_INT, default 341, width of concatenated pipeline-latch snapshot.
REQ-003 Parameter N_REGS, default 32, number of registers dumped.
REQ-004 Parameter N_MEM_WORDS, default 32, number of data-memory words dumped.
REQ-005 i_clk  input  1  single clock; all state on rising edge.
REQ-006 i_reset  input  1  asynchronous, active-high reset.
REQ-007 i_start  input  1  one-cycle dump request.
REQ-008 i_reg_data  input  NB_REG  register-file read data.
REQ-009 i_mem_data  input  NB_REG  data-memory read data.
REQ-010 i_latches_data  input  NB_R_INT  IF/ID, ID/EX, EX/M, M/WB concatenation.
REQ-011 i_tx_ready  input  1  UART transmitter can accept a byte.
REQ-012 o_tx_valid  output  1  byte on o_tx_data is offered.
REQ-013 o_tx_data  output  8  byte to transmit.
REQ-014 o_reg_addr  output  5  register-file read select.
REQ-015 o_mem_addr  output  32  data-memory byte read address.
REQ-016 o_busy  output  1  dump in progress.
REQ-017 o_done  output  1  one-cycle pulse at dump completion.

Function
REQ-018 States SHALL be IDLE, REG_RD, REG_TX, MEM_RD, MEM_TX, LAT_TX, CSUM_TX, FINISH.
REQ-019 IDLE->REG_RD on i_start; i_start while o_busy=1 SHALL be ignored.
REQ-020 On accepted i_start, i_latches_data SHALL be captured into a snapshot register; later changes not dumped.
REQ-021 Read latency is one cycle: address driven in *_RD, data captured into a 32-bit shift register on RD exit.
REQ-022 Byte transfer occurs on a cycle with o_tx_valid=1 and i_tx_ready=1; o_tx_data and o_tx_valid SHALL hold stable until transfer.
REQ-023 Words SHALL be sent as 4 bytes, least-significant byte first.
REQ-024 Register index counts 0..N_REGS-1; after 4th byte of index N_REGS-1, go to MEM_RD with index 0, else REG_RD with index+1.
REQ-025 o_mem_addr SHALL equal 4*index (word-aligned); index 0..N_MEM_WORDS-1, then LAT_TX.
REQ-026 LAT_TX sends ceil(NB_R_INT/8) bytes (43 default), snapshot zero-extended to a byte multiple, LSB byte first.
REQ-027 After last latch byte: CSUM_TX if enabled (REQ-033), else FINISH.
REQ-028 FINISH lasts one cycle, asserts o_done, returns to IDLE.
REQ-029 o_busy=1 in every state except IDLE.
REQ-030 Total bytes = 4*N_REGS + 4*N_MEM_WORDS + ceil(NB_R_INT/8) (+1 with checksum); 299 at defaults.
REQ-031 i_tx_ready held low SHALL stall indefinitely with no byte lost or duplicated.

Reset
REQ-032 Asserted i_reset, at any time including mid-dump, SHALL force IDLE, o_tx_valid=0, o_tx_data=0, o_reg_addr=0, o_mem_addr=0, o_busy=0, o_done=0, counters and snapshot cleared.

Configuration
REQ-033 Macro DUMP_CHECKSUM_EN defined: running XOR of all transferred bytes, reset on accepted i_start, sent as one final byte in CSUM_TX; undefined: no CSUM_TX state logic, no checksum byte.

Structure
REQ-034 Shared package SHALL hold the state enum, default NB_R_INT/N_REGS/N_MEM_WORDS constants and LAT_BYTES = ceil(NB_R_INT/8).
REQ-035 One sub-module, byte_serializer (word load, 4-byte valid/ready output), is natural; FSM and counters stay in dump_sequencer.

Verification
REQ-036 Regs hold 0x1000_0000+i, i_tx_ready=1, i_start pulse -> first bytes 00,00,00,10 then 01,00,00,10; o_reg_addr steps 0..31.
REQ-037 Full dump, defaults -> exactly 299 transfers (300 with DUMP_CHECKSUM_EN), o_done single pulse one cycle after last transfer.
REQ-038 Latches = 341'h1 with bit 340 set -> latch byte 0 = 0x01, byte 42 = 0x10.
REQ-039 i_tx_ready toggled randomly 30% high -> byte stream identical to REQ-037 run.
REQ-040 i_reset asserted after 50 transfers -> same cycle o_tx_valid=0, o_busy=0; new i_start restarts at register 0.
REQ-041 DUMP_CHECKSUM_EN, all data zero except reg 1 = 0x0000_00A5 -> checksum byte 0xA5; i_start during dump ignored.
